// File: rtl/seg7_scan_display_if.sv
// Bundle of display-side signals for seg7_scan_display: value/control in from the
// producer, multiplexed digit drive and frame pulse out to the panel.
interface seg7_scan_display_if;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_en;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  modport master (
    output enable, value, dp_in, blank_en,
    input  anode, seg, dp, frame_done
  );

  modport slave (
    input  enable, value, dp_in, blank_en,
    output anode, seg, dp, frame_done
  );
endinterface

// File: rtl/seg7_scan_display.sv
// 4-digit multiplexed hex display driver: refresh prescaler, digit scanner,
// frame-synchronous shadow latch, leading-zero blanking and per-digit decimal points.
module seg7_scan_display #(
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  seg7_scan_display_if.slave bus
);

  localparam int             CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic           INACT    = ACTIVE_LOW;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      4'hF:    s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] pick_nibble(input logic [15:0] val, input logic [1:0] dig);
    logic [3:0] n;
    case (dig)
      2'd0:    n = val[3:0];
      2'd1:    n = val[7:4];
      2'd2:    n = val[11:8];
      2'd3:    n = val[15:12];
      default: n = 4'h0;
    endcase
    return n;
  endfunction

  // A digit is a leading zero when it and every higher nibble are zero.
  function automatic logic is_leading_zero(input logic [15:0] val, input logic [1:0] dig);
    logic z;
    case (dig)
      2'd0:    z = 1'b0;
      2'd1:    z = (val[15:4] == 12'h000);
      2'd2:    z = (val[15:8] == 8'h00);
      2'd3:    z = (val[15:12] == 4'h0);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dig_q, dig_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic             resume_q, resume_d;
  logic [3:0]       anode_q, anode_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_done_q, frame_done_d;

  logic             tick_s;
  logic             show_s;
  logic [1:0]       show_dig_s;
  logic [15:0]      src_val_s;
  logic [3:0]       src_dp_s;
  logic             blank_s;

  // Next-state: prescaler, scanner, shadow capture and output decode.
  always_comb begin
    tick_s        = (cnt_q == CNT_LAST);
    cnt_d         = cnt_q;
    dig_d         = dig_q;
    shadow_d      = shadow_q;
    shadow_dp_d   = shadow_dp_q;
    resume_d      = resume_q;
    anode_d       = anode_q;
    seg_d         = seg_q;
    dp_d          = dp_q;
    frame_done_d  = 1'b0;
    show_s        = 1'b0;
    show_dig_s    = dig_q;
    src_val_s     = shadow_q;
    src_dp_s      = shadow_dp_q;
    blank_s       = 1'b0;

    if (!bus.enable) begin
      // Remember the pause so the held digit is re-lit on the first enabled edge.
      resume_d = 1'b1;
      anode_d  = {4{INACT}};
      seg_d    = {7{INACT}};
      dp_d     = INACT;
    end else begin
      resume_d = 1'b0;
      if (tick_s) begin
        cnt_d      = '0;
        dig_d      = dig_q + 2'd1;
        show_s     = 1'b1;
        show_dig_s = dig_q + 2'd1;
        if (dig_q == 2'd3) begin
          // Frame start: digit 0 bypasses the shadow so it shows the value just latched.
          shadow_d     = bus.value;
          shadow_dp_d  = bus.dp_in;
          src_val_s    = bus.value;
          src_dp_s     = bus.dp_in;
          frame_done_d = 1'b1;
        end else begin
          frame_done_d = 1'b0;
        end
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        show_s = resume_q;
      end

      if (show_s) begin
        blank_s = bus.blank_en && is_leading_zero(src_val_s, show_dig_s);
        if (blank_s) begin
          anode_d = {4{INACT}};
          seg_d   = {7{INACT}};
          dp_d    = INACT;
        end else begin
          anode_d = (4'b0001 << show_dig_s) ^ {4{INACT}};
          seg_d   = hex_to_seg(pick_nibble(src_val_s, show_dig_s)) ^ {7{INACT}};
          dp_d    = src_dp_s[show_dig_s] ^ INACT;
        end
      end else begin
        blank_s = 1'b0;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q        <= '0;
      dig_q        <= 2'd3;
      shadow_q     <= 16'h0000;
      shadow_dp_q  <= 4'h0;
      resume_q     <= 1'b0;
      anode_q      <= {4{INACT}};
      seg_q        <= {7{INACT}};
      dp_q         <= INACT;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      resume_q     <= resume_d;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.anode      = anode_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: one active-high instance and one active-low
// instance, both REFRESH_DIV=4, sharing clock and reset.
module tb_seg7_scan_display;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   edge_cnt;

  seg7_scan_display_if bus_a ();
  seg7_scan_display_if bus_b ();

  seg7_scan_display #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b0)) dut_a (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus_a.slave)
  );

  seg7_scan_display #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut_b (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus_b.slave)
  );

  always #5 clk = ~clk;

  // Rising edges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int e);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (edge_cnt < e && guard < 500);
    chk($sformatf("edge_reach_%0d", e), 16'(edge_cnt), 16'(e));
  endtask

  task automatic show_a(input string tag, input logic [3:0] an, input logic [6:0] sg);
    chk({tag, "_anode"}, {12'h000, bus_a.anode}, {12'h000, an});
    chk({tag, "_seg"},   {9'h000, bus_a.seg},    {9'h000, sg});
  endtask

  task automatic show_b(input string tag, input logic [3:0] an, input logic dp);
    chk({tag, "_anode"}, {12'h000, bus_b.anode}, {12'h000, an});
    chk({tag, "_seg"},   {9'h000, bus_b.seg},    16'h0000);
    chk({tag, "_dp"},    {15'h0000, bus_b.dp},   {15'h0000, dp});
  endtask

  task automatic reset_state(input string tag);
    show_a({tag, "_a"}, 4'b0000, 7'h00);
    chk({tag, "_a_dp"}, {15'h0000, bus_a.dp}, 16'h0000);
    chk({tag, "_a_fd"}, {15'h0000, bus_a.frame_done}, 16'h0000);
    chk({tag, "_b_anode"}, {12'h000, bus_b.anode}, 16'h000F);
    chk({tag, "_b_seg"},   {9'h000, bus_b.seg},    16'h007F);
    chk({tag, "_b_dp"},    {15'h0000, bus_b.dp},   16'h0001);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus_a.enable   = 1'b1;
    bus_a.value    = 16'h12AF;
    bus_a.dp_in    = 4'b0000;
    bus_a.blank_en = 1'b0;
    bus_b.enable   = 1'b1;
    bus_b.value    = 16'h8888;
    bus_b.dp_in    = 4'b0101;
    bus_b.blank_en = 1'b0;

    @(negedge clk);
    @(negedge clk);
    reset_state("por");
    rst_n = 1'b1;

    // Plain scan of 12AF, first lit digit on edge 4.
    goto(3);  show_a("pre_tick", 4'b0000, 7'h00);
    goto(4);  show_a("d0", 4'b0001, 7'h71);
    chk("fd_e4", {15'h0000, bus_a.frame_done}, 16'h0001);
    show_b("b_d0", 4'b1110, 1'b0);
    goto(5);  show_a("d0_hold", 4'b0001, 7'h71);
    chk("fd_e5", {15'h0000, bus_a.frame_done}, 16'h0000);
    goto(8);  show_a("d1", 4'b0010, 7'h77);
    show_b("b_d1", 4'b1101, 1'b1);
    goto(12); show_a("d2", 4'b0100, 7'h5B);
    show_b("b_d2", 4'b1011, 1'b0);
    goto(16); show_a("d3", 4'b1000, 7'h06);
    show_b("b_d3", 4'b0111, 1'b1);
    goto(19); chk("fd_e19", {15'h0000, bus_a.frame_done}, 16'h0000);
    goto(20); show_a("d0_f2", 4'b0001, 7'h71);
    chk("fd_e20", {15'h0000, bus_a.frame_done}, 16'h0001);

    // Mid-frame value change must not tear.
    goto(24); show_a("d1_f2", 4'b0010, 7'h77);
    bus_a.value = 16'h0000;
    goto(28); show_a("tear_d2", 4'b0100, 7'h5B);
    goto(32); show_a("tear_d3", 4'b1000, 7'h06);
    goto(36); show_a("new_d0", 4'b0001, 7'h3F);
    chk("fd_e36", {15'h0000, bus_a.frame_done}, 16'h0001);
    goto(40); show_a("new_d1", 4'b0010, 7'h3F);

    // Leading-zero blanking.
    bus_a.blank_en = 1'b1;
    bus_a.value    = 16'h0030;
    goto(44); show_a("blk_old_d2", 4'b0000, 7'h00);
    goto(48); show_a("blk_old_d3", 4'b0000, 7'h00);
    goto(52); show_a("blk_d0", 4'b0001, 7'h3F);
    goto(56); show_a("blk_d1", 4'b0010, 7'h4F);
    goto(60); show_a("blk_d2", 4'b0000, 7'h00);
    goto(64); show_a("blk_d3", 4'b0000, 7'h00);
    bus_a.value = 16'h0000;
    goto(68); show_a("z_d0", 4'b0001, 7'h3F);
    goto(72); show_a("z_d1", 4'b0000, 7'h00);
    goto(76); show_a("z_d2", 4'b0000, 7'h00);
    goto(80); show_a("z_d3", 4'b0000, 7'h00);
    bus_a.blank_en = 1'b0;
    bus_a.value    = 16'h12AF;

    // Pause mid-slot on digit 2 (count=1), resume and finish the slot.
    goto(92); show_a("p_d2", 4'b0100, 7'h5B);
    goto(93); show_a("p_d2b", 4'b0100, 7'h5B);
    bus_a.enable = 1'b0;
    goto(94); show_a("paused", 4'b0000, 7'h00);
    chk("paused_fd", {15'h0000, bus_a.frame_done}, 16'h0000);
    goto(103); show_a("paused_end", 4'b0000, 7'h00);
    bus_a.enable = 1'b1;
    goto(104); show_a("resume_d2", 4'b0100, 7'h5B);
    goto(105); show_a("resume_d2b", 4'b0100, 7'h5B);
    goto(106); show_a("resume_d3", 4'b1000, 7'h06);

    // Asynchronous reset between clock edges, then restart.
    #2;
    rst_n = 1'b0;
    #1;
    reset_state("async");
    @(negedge clk);
    rst_n = 1'b1;
    goto(3); show_a("rst2_pre", 4'b0000, 7'h00);
    goto(4); show_a("rst2_d0", 4'b0001, 7'h71);
    chk("rst2_fd", {15'h0000, bus_a.frame_done}, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
